controle_substantivo: RTL and testbench

//  Arbiter and sequencer for the shared noun classifier (substantivo) between two input keypads A and B.

---
 rtl/controle_substantivo.sv | 126 ++++++++++++
 tb/tb_controle_substantivo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/controle_substantivo.sv
// controle_substantivo: arbiter/sequencer sharing one noun classifier between keypads A and B
// Ports: clock/reset (sync, active-high); req_a/req_b + nota_a/nota_b requests, ack_a/ack_b grant pulses;
//        novo reopens a closed session; cls_ok/cls_nota drive the classifier, cls_tipo/cls_fim return its result;
//        fim session closed, tipo last result, dono last winner (0=A,1=B), estado FSM state, cont_* saturating tallies.
// Config macro PRIORIDADE_FIXA_EN: A always wins a tie (default: round-robin against dono).
module controle_substantivo #(
    parameter int CLS_LAT = 1,
    parameter int CW      = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [4:0]    nota_a,
    input  logic [4:0]    nota_b,
    output logic          ack_a,
    output logic          ack_b,
    input  logic          novo,
    output logic          cls_ok,
    output logic [4:0]    cls_nota,
    input  logic [1:0]    cls_tipo,
    input  logic          cls_fim,
    output logic          fim,
    output logic [1:0]    tipo,
    output logic          dono,
    output logic [2:0]    estado,
    output logic [CW-1:0] cont_concreto,
    output logic [CW-1:0] cont_abstrato,
    output logic [CW-1:0] cont_nomep
);
    typedef enum logic [2:0] {OCIOSO = 3'd0, ENVIA = 3'd1, ESPERA = 3'd2, REGISTRA = 3'd3, FIM = 3'd4} estado_t;
    localparam logic [CW-1:0] MAXC    = '1;
    // ESPERA lasts CLS_LAT-1 cycles: leave when the wait counter reaches CLS_LAT-2
    localparam logic [15:0]   ESP_FIM = 16'(CLS_LAT - 2);
    estado_t       st_q, st_d;
    logic [4:0]    nota_q, nota_d;
    logic          win_q, win_d, dono_q, dono_d, tie_b, pick_b;
    logic [1:0]    tipo_q, tipo_d;
    logic [CW-1:0] cc_q, cc_d, ca_q, ca_d, cn_q, cn_d;
    logic [15:0]   esp_q, esp_d;
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == MAXC) ? c : c + CW'(1);
    endfunction
`ifdef PRIORIDADE_FIXA_EN
    assign tie_b = 1'b0;
`else
    assign tie_b = ~dono_q;
`endif
    assign pick_b = req_b & (~req_a | tie_b);
    always_comb begin
        st_d   = st_q;
        nota_d = nota_q;
        win_d  = win_q;
        dono_d = dono_q;
        tipo_d = tipo_q;
        cc_d   = cc_q;
        ca_d   = ca_q;
        cn_d   = cn_q;
        esp_d  = esp_q;
        case (st_q)
            OCIOSO: if (req_a | req_b) begin
                win_d  = pick_b;
                nota_d = pick_b ? nota_b : nota_a;
                st_d   = ENVIA;
            end
            ENVIA: begin
                dono_d = win_q;
                esp_d  = '0;
                st_d   = (CLS_LAT > 1) ? ESPERA : REGISTRA;
            end
            ESPERA: begin
                esp_d = esp_q + 16'd1;
                st_d  = (esp_q == ESP_FIM) ? REGISTRA : ESPERA;
            end
            REGISTRA: begin
                tipo_d = cls_tipo;
                st_d   = cls_fim ? FIM : OCIOSO;
                cc_d   = (!cls_fim && cls_tipo == 2'b01) ? sat_inc(cc_q) : cc_q;
                ca_d   = (!cls_fim && cls_tipo == 2'b10) ? sat_inc(ca_q) : ca_q;
                cn_d   = (!cls_fim && cls_tipo == 2'b11) ? sat_inc(cn_q) : cn_q;
            end
            FIM: if (novo) begin
                st_d   = OCIOSO;
                tipo_d = '0;
                cc_d   = '0;
                ca_d   = '0;
                cn_d   = '0;
            end
            default: st_d = OCIOSO;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q   <= OCIOSO;
            nota_q <= '0;
            win_q  <= 1'b0;
            dono_q <= 1'b1;
            tipo_q <= '0;
            cc_q   <= '0;
            ca_q   <= '0;
            cn_q   <= '0;
            esp_q  <= '0;
        end else begin
            st_q   <= st_d;
            nota_q <= nota_d;
            win_q  <= win_d;
            dono_q <= dono_d;
            tipo_q <= tipo_d;
            cc_q   <= cc_d;
            ca_q   <= ca_d;
            cn_q   <= cn_d;
            esp_q  <= esp_d;
        end
    end
    assign cls_ok        = (st_q == ENVIA);
    assign ack_a         = cls_ok & ~win_q;
    assign ack_b         = cls_ok & win_q;
    assign cls_nota      = cls_ok ? nota_q : 5'd0;
    assign fim           = (st_q == FIM);
    assign tipo          = tipo_q;
    assign dono          = dono_q;
    assign estado        = st_q;
    assign cont_concreto = cc_q;
    assign cont_abstrato = ca_q;
    assign cont_nomep    = cn_q;
endmodule

// File: tb/tb_controle_substantivo.sv
// tb_controle_substantivo: randomized scoreboard bench for controle_substantivo
module tb_controle_substantivo;
    localparam int CLS_LAT = 2;
    localparam int CW      = 3;
    localparam int MAXV    = (1 << CW) - 1;
    localparam int NT      = 200;
    logic          clock, reset, req_a, req_b, novo, cls_fim;
    logic [4:0]    nota_a, nota_b, cls_nota;
    logic [1:0]    cls_tipo, tipo;
    logic          ack_a, ack_b, cls_ok, fim, dono;
    logic [2:0]    estado;
    logic [CW-1:0] cont_concreto, cont_abstrato, cont_nomep;
    typedef struct {int w; int nota; int tipo; int cc; int ca; int cn; int fim; int dono; int est;} exp_t;
    typedef struct {int t; int f;} rsp_t;
    exp_t exp_q[$];
    rsp_t rsp_q[$];
    int checks = 0, errors = 0;
    int m_dono = 1, m_tipo = 0, m_cc = 0, m_ca = 0, m_cn = 0, m_fim = 0;

    controle_substantivo #(.CLS_LAT(CLS_LAT), .CW(CW)) dut (
        .clock(clock), .reset(reset), .req_a(req_a), .req_b(req_b), .nota_a(nota_a), .nota_b(nota_b),
        .ack_a(ack_a), .ack_b(ack_b), .novo(novo), .cls_ok(cls_ok), .cls_nota(cls_nota),
        .cls_tipo(cls_tipo), .cls_fim(cls_fim), .fim(fim), .tipo(tipo), .dono(dono), .estado(estado),
        .cont_concreto(cont_concreto), .cont_abstrato(cont_abstrato), .cont_nomep(cont_nomep)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic model_clear();
        m_tipo = 0; m_cc = 0; m_ca = 0; m_cn = 0; m_fim = 0;
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, "_estado"}, int'(estado), 0);
        chk({tag, "_fim"}, int'(fim), 0);
        chk({tag, "_cls_ok"}, int'(cls_ok), 0);
        chk({tag, "_acks"}, int'(ack_a | ack_b), 0);
        chk({tag, "_tipo"}, int'(tipo), 0);
        chk({tag, "_cc"}, int'(cont_concreto), 0);
        chk({tag, "_ca"}, int'(cont_abstrato), 0);
        chk({tag, "_cn"}, int'(cont_nomep), 0);
    endtask

    task automatic wait_ack(input bit rand_novo);
        int k = 0;
        while (!(ack_a || ack_b) && k < 12) begin
            @(negedge clock);
            novo = rand_novo && ($urandom_range(3, 0) == 0);
            k++;
        end
        novo = 1'b0;
        if (k >= 12) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack, expected one within 12 cycles (t=%0t)", $time);
            finish_sim();
        end
    endtask

    // Monitor: every grant pops the oldest expectation; results are checked the cycle after REGISTRA.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (cls_ok || ack_a || ack_b) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got cls_ok=%0d ack_a=%0d ack_b=%0d, expected none (t=%0t)",
                             cls_ok, ack_a, ack_b, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("cls_ok", int'(cls_ok), 1);
                    chk("ack_a", int'(ack_a), 1 - e.w);
                    chk("ack_b", int'(ack_b), e.w);
                    chk("cls_nota", int'(cls_nota), e.nota);
                    repeat (CLS_LAT + 1) @(negedge clock);
                    chk("tipo", int'(tipo), e.tipo);
                    chk("cont_concreto", int'(cont_concreto), e.cc);
                    chk("cont_abstrato", int'(cont_abstrato), e.ca);
                    chk("cont_nomep", int'(cont_nomep), e.cn);
                    chk("fim", int'(fim), e.fim);
                    chk("dono", int'(dono), e.dono);
                    chk("estado", int'(estado), e.est);
                end
            end
        end
    end

    // Classifier model: answers CLS_LAT cycles after cls_ok, random noise on every other cycle.
    initial begin
        rsp_t r;
        cls_tipo = 2'b00;
        cls_fim  = 1'b0;
        forever begin
            @(negedge clock);
            if (cls_ok) begin
                r = (rsp_q.size() != 0) ? rsp_q.pop_front() : '{0, 0};
                repeat (CLS_LAT) @(negedge clock);
                cls_tipo = 2'(r.t);
                cls_fim  = 1'(r.f);
                @(negedge clock);
            end
            cls_tipo = 2'($urandom);
            cls_fim  = 1'($urandom);
        end
    end

    task automatic run_txn();
        int w, t, f, tie;
        exp_t e;
        if (!req_a && $urandom_range(1, 0) == 1) begin req_a = 1'b1; nota_a = 5'($urandom); end
        if (!req_b && $urandom_range(1, 0) == 1) begin req_b = 1'b1; nota_b = 5'($urandom); end
        if (!req_a && !req_b) begin req_a = 1'b1; nota_a = 5'($urandom); end
`ifdef PRIORIDADE_FIXA_EN
        tie = 0;
`else
        tie = 1 - m_dono;
`endif
        w = (req_a && req_b) ? tie : (req_b ? 1 : 0);
        t = $urandom_range(3, 0);
        f = ($urandom_range(39, 0) == 0) ? 1 : 0;
        m_dono = w;
        m_tipo = t;
        if (f == 1) m_fim = 1;
        else if (t == 1) m_cc = (m_cc < MAXV) ? m_cc + 1 : m_cc;
        else if (t == 2) m_ca = (m_ca < MAXV) ? m_ca + 1 : m_ca;
        else if (t == 3) m_cn = (m_cn < MAXV) ? m_cn + 1 : m_cn;
        e = '{w, (w == 1) ? int'(nota_b) : int'(nota_a), m_tipo, m_cc, m_ca, m_cn, m_fim, m_dono, (m_fim == 1) ? 4 : 0};
        exp_q.push_back(e);
        rsp_q.push_back('{t, f});
        wait_ack(1'b1);
        if (w == 1) req_b = 1'b0; else req_a = 1'b0;
        repeat (CLS_LAT) @(negedge clock);
        if (m_fim == 1) begin
            repeat (2) @(negedge clock);
            if (!req_b) begin req_b = 1'b1; nota_b = 5'($urandom); end
            for (int i = 0; i < 4; i++) begin
                chk("fim_held", int'(fim), 1);
                chk("ack_in_fim", int'(ack_a | ack_b), 0);
                @(negedge clock);
            end
            novo = 1'b1;
            @(negedge clock);
            novo = 1'b0;
            model_clear();
            chk("novo_fim", int'(fim), 0);
            chk("novo_estado", int'(estado), 0);
            chk("novo_tipo", int'(tipo), 0);
            chk("novo_cc", int'(cont_concreto), 0);
            chk("novo_ca", int'(cont_abstrato), 0);
            chk("novo_cn", int'(cont_nomep), 0);
        end
    endtask

    initial begin
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; novo = 1'b0; nota_a = '0; nota_b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_idle_state("rst");
        chk("rst_dono", int'(dono), 1);
        for (int n = 0; n < NT; n++) run_txn();
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) @(negedge clock);
        // Reset while waiting for the classifier drops the transaction entirely.
        req_a  = 1'b1;
        nota_a = 5'h07;
        exp_q.push_back('{0, 7, 0, 0, 0, 0, 0, 1, 0});
        rsp_q.push_back('{1, 1});
        wait_ack(1'b0);
        req_a = 1'b0;
        @(negedge clock);
        chk("pre_reset_espera", int'(estado), 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_dono = 1;
        model_clear();
        check_idle_state("midrst");
        chk("midrst_dono", int'(dono), 1);
        repeat (4) @(negedge clock);
        check_idle_state("late_rsp");
        for (int n = 0; n < 20; n++) run_txn();
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (6) @(negedge clock);
        chk("exp_q_drained", exp_q.size(), 0);
        finish_sim();
    end
endmodule
